// File: rtl/edge_detect_multi.sv
// Multi-channel level-to-tick edge detector. Each channel has an input synchroniser,
// a debounce filter, a mode-gated one-cycle tick and a sticky event flag.
module edge_detect_multi #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter bit INIT_LEVEL  = 1'b0
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   level,
  input  logic [2*N-1:0] mode,
  input  logic [N-1:0]   clr,
  output logic [N-1:0]   tick,
  output logic [N-1:0]   level_db,
  output logic [N-1:0]   event_flag
);

  localparam int            CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   tick_q, tick_d;
    logic                   flag_q, flag_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], level[i]};
      cnt_d  = '0;
      db_d   = db_q;
      tick_d = 1'b0;
      // Any cycle where s agrees with the debounced level restarts the count.
      if (s != db_q) begin
        if (cnt_q == CNT_LAST) begin
          db_d   = s;
          tick_d = s ? mode[2*i] : mode[2*i+1];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      flag_d = tick_q | (flag_q & ~clr[i]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_q <= {SYNC_STAGES{INIT_LEVEL}};
        cnt_q  <= '0;
        db_q   <= INIT_LEVEL;
        tick_q <= 1'b0;
        flag_q <= 1'b0;
      end else begin
        sync_q <= sync_d;
        cnt_q  <= cnt_d;
        db_q   <= db_d;
        tick_q <= tick_d;
        flag_q <= flag_d;
      end
    end

    assign tick[i]       = tick_q;
    assign level_db[i]   = db_q;
    assign event_flag[i] = flag_q;
  end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Bench for edge_detect_multi: default configuration plus an N=8, 3-stage, DB=1,
// INIT=1 configuration, both checked every cycle against a window-based model.
module tb_edge_detect_multi;

  logic        clk;
  logic [1:0]  rstn;
  logic [7:0]  lvl   [2];
  logic [15:0] md    [2];
  logic [7:0]  clr_v [2];

  logic [3:0] tk0, db0, fl0;
  logic [7:0] tk1, db1, fl1;

  int errors = 0;
  int checks = 0;
  int tcnt [4];

  // Model state: raw sample history (bit 0 = newest), debounced level, tick, flag.
  bit [15:0] hist  [2][8];
  bit [7:0]  mdb   [2];
  bit [7:0]  mtick [2];
  bit [7:0]  mflag [2];

  edge_detect_multi #(.N(4), .SYNC_STAGES(2), .DB_CYCLES(4), .INIT_LEVEL(1'b0)) u_dut0 (
    .clk(clk), .reset_n(rstn[0]), .level(lvl[0][3:0]), .mode(md[0][7:0]),
    .clr(clr_v[0][3:0]), .tick(tk0), .level_db(db0), .event_flag(fl0));

  edge_detect_multi #(.N(8), .SYNC_STAGES(3), .DB_CYCLES(1), .INIT_LEVEL(1'b1)) u_dut1 (
    .clk(clk), .reset_n(rstn[1]), .level(lvl[1]), .mode(md[1]),
    .clr(clr_v[1]), .tick(tk1), .level_db(db1), .event_flag(fl1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int s_of(int c);  return (c == 1) ? 3 : 2; endfunction
  function automatic int db_of(int c); return (c == 1) ? 1 : 4; endfunction
  function automatic int n_of(int c);  return (c == 1) ? 8 : 4; endfunction

  task automatic model_reset(int c);
    bit init;
    init = (c == 1);
    for (int i = 0; i < 8; i++) begin
      hist[c][i]  = {16{init}};
      mdb[c][i]   = init;
      mtick[c][i] = 1'b0;
      mflag[c][i] = 1'b0;
    end
  endtask

  // The debounced level flips when the last DB synchronised samples all differ from it.
  task automatic model_step(int c);
    bit flip;
    for (int i = 0; i < n_of(c); i++) begin
      flip = 1'b1;
      for (int j = s_of(c) - 1; j <= s_of(c) + db_of(c) - 2; j++)
        if (hist[c][i][j] == mdb[c][i]) flip = 1'b0;
      mflag[c][i] = mtick[c][i] | (mflag[c][i] & ~clr_v[c][i]);
      mtick[c][i] = 1'b0;
      if (flip) begin
        mdb[c][i]   = ~mdb[c][i];
        mtick[c][i] = mdb[c][i] ? md[c][2*i] : md[c][2*i+1];
      end
      hist[c][i] = {hist[c][i][14:0], lvl[c][i]};
    end
  endtask

  always @(posedge clk or negedge rstn[0])
    if (!rstn[0]) model_reset(0); else model_step(0);

  always @(posedge clk or negedge rstn[1])
    if (!rstn[1]) model_reset(1); else model_step(1);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("c0_tick",  32'(tk0), 32'(mtick[0]));
    chk("c0_db",    32'(db0), 32'(mdb[0]));
    chk("c0_flag",  32'(fl0), 32'(mflag[0]));
    chk("c1_tick",  32'(tk1), 32'(mtick[1]));
    chk("c1_db",    32'(db1), 32'(mdb[1]));
    chk("c1_flag",  32'(fl1), 32'(mflag[1]));
    for (int i = 0; i < 4; i++) if (tk0[i] === 1'b1) tcnt[i]++;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      compare();
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) tcnt[i] = 0;
  endtask

  initial begin
    rstn     = 2'b11;
    lvl[0]   = 8'h00;  lvl[1]   = 8'hFF;
    md[0]    = 16'h0;  md[1]    = 16'hAAAA;
    clr_v[0] = 8'h00;  clr_v[1] = 8'h00;
    clear_counts();
    #1 rstn = 2'b00;
    cyc(3);
    chk("rst_tick0", 32'(tk0), 0);
    chk("rst_db0",   32'(db0), 0);
    chk("rst_flag0", 32'(fl0), 0);
    chk("rst_db1",   32'(db1), 32'hFF);
    chk("rst_tick1", 32'(tk1), 0);
    rstn = 2'b11;

    // Wide configuration: inputs held at INIT through release, then dropped.
    cyc(4);
    chk("c1_no_release_tick", 32'(tk1), 0);
    chk("c1_db_held", 32'(db1), 32'hFF);
    lvl[1] = 8'h00;
    cyc(3);
    chk("c1_tick_e3", 32'(tk1), 0);
    cyc(1);
    chk("c1_tick_e4", 32'(tk1), 32'hFF);
    chk("c1_db_e4",   32'(db1), 0);
    cyc(1);
    chk("c1_tick_e5", 32'(tk1), 0);
    chk("c1_flag_e5", 32'(fl1), 32'hFF);

    // Rising edge on ch0: tick after the 6th sampling edge, one cycle wide.
    md[0] = 16'h0001;
    lvl[0][0] = 1'b1;
    cyc(5);
    chk("t1_tick_e5", 32'(tk0), 0);
    chk("t1_db_e5",   32'(db0), 0);
    cyc(1);
    chk("t1_tick_e6", 32'(tk0), 32'h1);
    chk("t1_db_e6",   32'(db0), 32'h1);
    cyc(1);
    chk("t1_tick_e7", 32'(tk0), 0);
    chk("t1_flag_e7", 32'(fl0), 32'h1);
    cyc(13);
    chk("t1_flag_hold", 32'(fl0), 32'h1);

    // Glitch rejection on ch1 (both edges).
    md[0] = 16'h000D;
    clear_counts();
    lvl[0][1] = 1'b1; cyc(3);
    lvl[0][1] = 1'b0; cyc(10);
    chk("t2_short_ticks", 32'(tcnt[1]), 0);
    chk("t2_short_db",    32'(db0[1]), 0);
    lvl[0][1] = 1'b1; cyc(4);
    lvl[0][1] = 1'b0; cyc(3);
    chk("t2_rise_ticks", 32'(tcnt[1]), 1);
    cyc(9);
    chk("t2_total_ticks", 32'(tcnt[1]), 2);

    // Mode coverage: same waveform on all channels, modes 00/01/10/11.
    md[0] = 16'h0000;
    lvl[0] = 8'h00; cyc(10);
    md[0] = 16'h00E4;
    clear_counts();
    lvl[0] = 8'h0F; cyc(10);
    chk("t3_db_high", 32'(db0), 32'hF);
    lvl[0] = 8'h00; cyc(10);
    chk("t3_db_low", 32'(db0), 0);
    chk("t3_cnt0", 32'(tcnt[0]), 0);
    chk("t3_cnt1", 32'(tcnt[1]), 1);
    chk("t3_cnt2", 32'(tcnt[2]), 1);
    chk("t3_cnt3", 32'(tcnt[3]), 2);

    // Flag clear alone, then clear coinciding with a tick.
    clr_v[0] = 8'h04; cyc(1);
    clr_v[0] = 8'h00;
    chk("t4_cleared", 32'(fl0[2]), 0);
    lvl[0][2] = 1'b1; cyc(10);
    lvl[0][2] = 1'b0; cyc(5);
    chk("t4_tick_e5", 32'(tk0[2]), 0);
    cyc(1);
    chk("t4_tick_e6", 32'(tk0[2]), 1);
    chk("t4_flag_e6", 32'(fl0[2]), 0);
    clr_v[0] = 8'h04; cyc(1);
    clr_v[0] = 8'h00;
    chk("t4_set_wins", 32'(fl0[2]), 1);
    cyc(2);
    chk("t4_flag_hold", 32'(fl0[2]), 1);

    // Reset in the middle of a debounce count on ch3.
    lvl[0][3] = 1'b1;
    cyc(4);
    #2 rstn[0] = 1'b0;
    #1;
    chk("t5_async_tick", 32'(tk0), 0);
    chk("t5_async_db",   32'(db0), 0);
    chk("t5_async_flag", 32'(fl0), 0);
    cyc(5);
    rstn[0] = 1'b1;
    cyc(1);
    chk("t5_no_release_tick", 32'(tk0), 0);
    cyc(4);
    chk("t5_tick_e5", 32'(tk0[3]), 0);
    cyc(1);
    chk("t5_tick_e6", 32'(tk0[3]), 1);
    chk("t5_db_e6",   32'(db0[3]), 1);

    // Randomised traffic on both configurations with occasional async resets.
    for (int k = 0; k < 600; k++) begin
      rstn = 2'b11;
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < n_of(c); i++)
          if ($urandom_range(5) == 0) lvl[c][i] = ~lvl[c][i];
        if ($urandom_range(39) == 0) md[c] = 16'($urandom);
        clr_v[c] = 8'($urandom) & 8'($urandom) & 8'($urandom);
      end
      if ($urandom_range(99) == 0) begin
        #2 rstn[$urandom_range(1)] = 1'b0;
      end
      cyc(1);
    end
    rstn = 2'b11;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
